// File: rtl/serial_parallel_lanes_if.sv
// -----------------------------------------------------------------------------
// serial_parallel_lanes_if
// Handshake bundle between a narrow serial front end and a word-wide consumer.
//   serial_in_valid    beat offered by the serial source
//   serial_in_ready    deserialiser can take the beat this cycle
//   serial_in          beat data, LANE_WIDTH bits
//   parallel_out_valid assembled word available
//   parallel_out_ready consumer takes the word this cycle
//   parallel_out       assembled word, WORD_WIDTH bits
//   parallel_out_beats number of beats of real data in parallel_out
// Modports: slave  = deserialiser side (accepts beats, offers words)
//           master = environment side (offers beats, consumes words)
// -----------------------------------------------------------------------------
interface serial_parallel_lanes_if #(
    parameter int WORD_WIDTH = 8,
    parameter int LANE_WIDTH = 1,
    parameter int BEAT_CNT_W = $clog2(WORD_WIDTH / LANE_WIDTH + 1)
) ();
    logic                  serial_in_valid;
    logic                  serial_in_ready;
    logic [LANE_WIDTH-1:0] serial_in;
    logic                  parallel_out_valid;
    logic                  parallel_out_ready;
    logic [WORD_WIDTH-1:0] parallel_out;
    logic [BEAT_CNT_W-1:0] parallel_out_beats;

    modport slave (
        input  serial_in_valid,
        input  serial_in,
        input  parallel_out_ready,
        output serial_in_ready,
        output parallel_out_valid,
        output parallel_out,
        output parallel_out_beats
    );

    modport master (
        output serial_in_valid,
        output serial_in,
        output parallel_out_ready,
        input  serial_in_ready,
        input  parallel_out_valid,
        input  parallel_out,
        input  parallel_out_beats
    );
endinterface

// File: rtl/serial_parallel_lanes.sv
// -----------------------------------------------------------------------------
// serial_parallel_lanes
// Deserialiser: collects WORD_WIDTH/LANE_WIDTH beats of LANE_WIDTH bits into
// one word, MSB- or LSB-first. A flush closes a partial word, justified as if
// zero beats had followed. One beat per cycle with no bubble at word borders.
// Ports:
//   i_clock         rising-edge clock
//   i_clear         synchronous active-high reset, overrides i_clock_enable
//   i_clock_enable  0 freezes all state and blocks both handshakes
//   i_flush         close the current partial word (level, sampled each cycle)
//   io_lanes        serial_parallel_lanes_if.slave handshake bundle
// -----------------------------------------------------------------------------
module serial_parallel_lanes #(
    parameter int WORD_WIDTH = 8,
    parameter int LANE_WIDTH = 1,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                    i_clock,
    input  logic                    i_clear,
    input  logic                    i_clock_enable,
    input  logic                    i_flush,
    serial_parallel_lanes_if.slave  io_lanes
);
    localparam int BEATS      = WORD_WIDTH / LANE_WIDTH;
    localparam int BEAT_CNT_W = $clog2(BEATS + 1);

    typedef enum logic {
        FILLING = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                r_state;
    logic [WORD_WIDTH-1:0] r_word;
    logic [BEAT_CNT_W-1:0] r_count;
    logic [BEAT_CNT_W-1:0] r_beats;

    state_t                w_nxt_state;
    logic [WORD_WIDTH-1:0] w_nxt_word;
    logic [BEAT_CNT_W-1:0] w_nxt_count;
    logic [BEAT_CNT_W-1:0] w_nxt_beats;

    logic                  w_full;
    logic                  w_out_valid;
    logic                  w_in_ready;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic [WORD_WIDTH-1:0] w_lane_ext;
    logic [WORD_WIDTH-1:0] w_base_word;
    logic [BEAT_CNT_W-1:0] w_base_count;
    logic [WORD_WIDTH-1:0] w_fill_word;
    logic [BEAT_CNT_W-1:0] w_k;
    logic [31:0]           w_pad;

    assign w_full      = (r_state == FULL);
    assign w_out_valid = w_full && i_clock_enable;
    // Ready never looks at serial_in_valid, so no combinational loop with the source.
    assign w_in_ready  = i_clock_enable && (!w_full || io_lanes.parallel_out_ready);
    assign w_in_hs     = io_lanes.serial_in_valid && w_in_ready;
    assign w_out_hs    = w_out_valid && io_lanes.parallel_out_ready;

    assign io_lanes.serial_in_ready    = w_in_ready;
    assign io_lanes.parallel_out_valid = w_out_valid;
    assign io_lanes.parallel_out       = r_word;
    assign io_lanes.parallel_out_beats = r_beats;

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_state <= FILLING;
            r_word  <= '0;
            r_count <= '0;
            r_beats <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_word  <= w_nxt_word;
            r_count <= w_nxt_count;
            r_beats <= w_nxt_beats;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_word  = r_word;
        w_nxt_count = r_count;
        w_nxt_beats = r_beats;

        // When a held word is consumed this cycle, the fill path restarts from
        // an empty word, so a same-cycle beat becomes beat 0 of the next word.
        w_lane_ext   = WORD_WIDTH'(io_lanes.serial_in);
        w_base_word  = w_full ? '0 : r_word;
        w_base_count = w_full ? '0 : r_count;

        if (MSB_FIRST) begin
            w_fill_word = w_in_hs ? ((w_base_word << LANE_WIDTH) | w_lane_ext) : w_base_word;
        end else begin
            w_fill_word = w_in_hs ? ((w_base_word >> LANE_WIDTH) |
                                     (w_lane_ext << (WORD_WIDTH - LANE_WIDTH)))
                                  : w_base_word;
        end

        w_k   = w_base_count + BEAT_CNT_W'(w_in_hs);
        // Lanes still missing from a flushed word; only meaningful when w_k < BEATS.
        w_pad = (BEATS - 32'(w_k)) * LANE_WIDTH;

        if (i_clock_enable && (!w_full || w_out_hs)) begin
            w_nxt_state = FILLING;
            w_nxt_word  = w_fill_word;
            w_nxt_count = w_k;
            if (w_k == BEAT_CNT_W'(BEATS)) begin
                w_nxt_state = FULL;
                w_nxt_beats = BEAT_CNT_W'(BEATS);
                w_nxt_count = '0;
            end else if (i_flush && !w_full && (w_k != '0)) begin
                // Justify the partial word as if zero beats had followed.
                w_nxt_state = FULL;
                w_nxt_beats = w_k;
                w_nxt_count = '0;
                w_nxt_word  = MSB_FIRST ? (w_fill_word << w_pad) : (w_fill_word >> w_pad);
            end
        end
    end
endmodule
